// File: rtl/wb_timer_if.sv
// wb_timer_if: Wishbone B3 classic bus bundle for the wb_timer peripheral.
//   wb_adr_i  [4:0]  byte address (bits [1:0] ignored by the slave)
//   wb_dat_i  [31:0] write data
//   wb_sel_i  [3:0]  byte enables for writes
//   wb_we_i          write strobe
//   wb_cyc_i         bus cycle
//   wb_stb_i         bus strobe
//   wb_dat_o  [31:0] read data, valid while wb_ack_o is high
//   wb_ack_o         transfer acknowledge
//   wb_err_o         unmapped-address error
interface wb_timer_if;
    logic [4:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_timer.sv
// wb_timer: Wishbone B3 classic slave with a 32-bit up-counting timer,
// programmable prescaler, compare match and a level interrupt.
//   wb_clk_i   clock (single domain)
//   nrst_i     asynchronous active-low reset
//   wb         Wishbone slave bundle (wb_timer_if.slave)
//   int_o      level interrupt = MATCH & IRQ_EN
// Register map (word offsets): 0x00 CTRL {IRQ_EN,PERIODIC,EN}, 0x04 PRESCALE,
// 0x08 COMPARE, 0x0C COUNT, 0x10 STATUS {MATCH, write-1-to-clear};
// 0x14..0x1C answer with wb_err_o.
module wb_timer #(
    parameter int unsigned PRESCALE_W  = 16,
    parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
    input  logic      wb_clk_i,
    input  logic      nrst_i,
    wb_timer_if.slave wb,
    output logic      int_o
);
    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_PRESCALE = 3'd1,
        REG_COMPARE  = 3'd2,
        REG_COUNT    = 3'd3,
        REG_STATUS   = 3'd4
    } reg_e;

    logic                  en_q, en_d, periodic_q, periodic_d, irq_en_q, irq_en_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d, pre_q, pre_d;
    logic [31:0]           compare_q, compare_d, count_q, count_d;
    logic                  match_q, match_d;
    logic                  ack_q, ack_d, err_q, err_d;
    logic [31:0]           dat_q, dat_d;

    logic        req, mapped, wr;
    logic [2:0]  widx;
    logic        wr_ctrl, wr_prescale, wr_compare, wr_count, status_clr;
    logic        tick, hit;
    logic [31:0] rdata;
    logic        unused_adr;

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
        logic [31:0] r;
        for (int unsigned b = 0; b < 4; b++)
            r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return r;
    endfunction

    // A request is not accepted in the cycle its response is on the bus,
    // which forces at least two cycles per transfer when stb is held.
    assign req         = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
    assign widx        = wb.wb_adr_i[4:2];
    assign unused_adr  = ^wb.wb_adr_i[1:0];
    assign mapped      = (widx <= REG_STATUS);
    assign wr          = req & mapped & wb.wb_we_i;
    assign wr_ctrl     = wr & (widx == REG_CTRL) & wb.wb_sel_i[0];
    assign wr_prescale = wr & (widx == REG_PRESCALE);
    assign wr_compare  = wr & (widx == REG_COMPARE);
    assign wr_count    = wr & (widx == REG_COUNT);
    assign status_clr  = wr & (widx == REG_STATUS) & wb.wb_sel_i[0] & wb.wb_dat_i[0];

    assign tick = en_q & (pre_q == prescale_q);
    // A COUNT write on a tick discards that tick's compare as well as its increment.
    assign hit  = tick & (count_q == compare_q) & ~wr_count;

    always_comb begin
        rdata = '0;
        case (widx)
            REG_CTRL:     rdata = {29'd0, irq_en_q, periodic_q, en_q};
            REG_PRESCALE: rdata = 32'(prescale_q);
            REG_COMPARE:  rdata = compare_q;
            REG_COUNT:    rdata = count_q;
            REG_STATUS:   rdata = {31'd0, match_q};
            default:      rdata = '0;
        endcase
    end

    assign ack_d = req & mapped;
    assign err_d = req & ~mapped;
    assign dat_d = (req & mapped) ? rdata : '0;

    always_comb begin
        en_d       = en_q;
        periodic_d = periodic_q;
        irq_en_d   = irq_en_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        count_d    = count_q;
        pre_d      = pre_q;

        if (en_q)
            pre_d = tick ? '0 : pre_q + PRESCALE_W'(1);

        if (wr_count)
            count_d = merge(count_q, wb.wb_dat_i, wb.wb_sel_i);
        else if (tick)
            count_d = (count_q == compare_q) ? '0 : count_q + 32'd1;

        // Set has priority over a simultaneous write-1-to-clear.
        match_d = hit | (match_q & ~status_clr);

        if (hit && !periodic_q)
            en_d = 1'b0;

        // The written EN overrides a same-cycle one-shot auto-clear.
        if (wr_ctrl) begin
            en_d       = wb.wb_dat_i[0];
            periodic_d = wb.wb_dat_i[1];
            irq_en_d   = wb.wb_dat_i[2];
            if (wb.wb_dat_i[0] && !en_q)
                pre_d = '0;
        end

        if (wr_prescale)
            prescale_d = PRESCALE_W'(merge(32'(prescale_q), wb.wb_dat_i, wb.wb_sel_i));
        if (wr_compare)
            compare_d = merge(compare_q, wb.wb_dat_i, wb.wb_sel_i);
    end

    always_ff @(posedge wb_clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            en_q       <= 1'b0;
            periodic_q <= 1'b0;
            irq_en_q   <= 1'b0;
            prescale_q <= '0;
            compare_q  <= COMPARE_RST;
            count_q    <= '0;
            pre_q      <= '0;
            match_q    <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            en_q       <= en_d;
            periodic_q <= periodic_d;
            irq_en_q   <= irq_en_d;
            prescale_q <= prescale_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            pre_q      <= pre_d;
            match_q    <= match_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = dat_q;
    assign int_o       = match_q & irq_en_q;
endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: scoreboard bench for wb_timer. A reference model of the
// timer rules queues the expected response of every accepted request; a
// monitor pops and compares on each ack/err and checks int_o every cycle.
module tb_wb_timer;
    localparam int unsigned PW    = 16;
    localparam int unsigned CLK_T = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic int_o;

    wb_timer_if bus();

    wb_timer #(.PRESCALE_W(PW), .COMPARE_RST(32'hFFFF_FFFF)) dut (
        .wb_clk_i (clk),
        .nrst_i   (rst_n),
        .wb       (bus),
        .int_o    (int_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [31:0] dat;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   acks_seen  = 0;
    time  t_edge     = 0;

    // Reference model state
    bit          m_en, m_per, m_irq, m_match, m_busy;
    int unsigned m_prl, m_phase;
    logic [31:0] m_cmp, m_cnt;

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int unsigned idx);
        case (idx)
            0:       return {29'd0, m_irq, m_per, m_en};
            1:       return m_prl;
            2:       return m_cmp;
            3:       return m_cnt;
            4:       return {31'd0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_per = 0; m_irq = 0; m_match = 0; m_busy = 0;
        m_prl = 0; m_phase = 0; m_cmp = 32'hFFFF_FFFF; m_cnt = 32'd0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit          req, wr, tick, cnt_wr, hit, old_en;
        int unsigned idx;
        logic [31:0] d;
        logic [3:0]  s;
        exp_t        e;
        req    = bus.wb_cyc_i && bus.wb_stb_i && !m_busy;
        m_busy = req;
        idx    = {27'd0, bus.wb_adr_i} >> 2;
        d      = bus.wb_dat_i;
        s      = bus.wb_sel_i;
        wr     = req && bus.wb_we_i && idx <= 4;
        if (req) begin
            e.err = (idx > 4);
            e.dat = e.err ? 32'd0 : m_read(idx);
            exp_q.push_back(e);
        end
        tick   = m_en && (m_phase == m_prl);
        cnt_wr = wr && idx == 3;
        hit    = tick && (m_cnt == m_cmp) && !cnt_wr;
        old_en = m_en;
        if (m_en) m_phase = tick ? 0 : (m_phase + 1) % (1 << PW);
        if (cnt_wr) m_cnt = bmerge(m_cnt, d, s);
        else if (tick) m_cnt = (m_cnt == m_cmp) ? 32'd0 : m_cnt + 32'd1;
        m_match = hit || (m_match && !(wr && idx == 4 && s[0] && d[0]));
        if (hit && !m_per) m_en = 0;
        if (wr && idx == 0 && s[0]) begin
            m_en = d[0]; m_per = d[1]; m_irq = d[2];
            if (d[0] && !old_en) m_phase = 0;
        end
        if (wr && idx == 1) m_prl = bmerge(m_prl, d, s) & ((1 << PW) - 1);
        if (wr && idx == 2) m_cmp = bmerge(m_cmp, d, s);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checks++;
                if (int_o !== (m_match && m_irq)) begin
                    failures++;
                    $display("FAIL int_o: got %0b want %0b at %0t", int_o, m_match && m_irq, $time);
                end
                if (bus.wb_ack_o || bus.wb_err_o) begin
                    acks_seen++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_resp: got ack=%0b err=%0b want none at %0t",
                                 bus.wb_ack_o, bus.wb_err_o, $time);
                    end else begin
                        e = exp_q.pop_front();
                        if ({bus.wb_ack_o, bus.wb_err_o} !== {!e.err, e.err} || bus.wb_dat_o !== e.dat) begin
                            failures++;
                            $display("FAIL bus_resp: got ack=%0b err=%0b dat=0x%08h want ack=%0b err=%0b dat=0x%08h at %0t",
                                     bus.wb_ack_o, bus.wb_err_o, bus.wb_dat_o, !e.err, e.err, e.dat, $time);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic bus_idle();
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge following the ack.
    task automatic xfer(input bit we, input int unsigned idx, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rd_v, output bit er);
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = we;
        bus.wb_adr_i = {idx[2:0], 2'($urandom_range(0, 3))};
        bus.wb_dat_i = dat; bus.wb_sel_i = sel;
        @(posedge clk);
        t_edge = $time;
        #1;
        rd_v = bus.wb_dat_o;
        er   = bus.wb_err_o;
        bus_idle();
        idle(1);
    endtask

    task automatic wr(input int unsigned idx, input logic [31:0] d);
        logic [31:0] r; bit e;
        xfer(1'b1, idx, d, 4'hF, r, e);
    endtask

    task automatic rd(input int unsigned idx, output logic [31:0] r);
        bit e;
        xfer(1'b0, idx, 32'd0, 4'hF, r, e);
    endtask

    task automatic wait_int(output time te, output bit ok);
        ok = 0;
        te = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            te = $time;
            #1;
            if (int_o) begin ok = 1; break; end
        end
    endtask

    initial begin
        logic [31:0] r;
        bit          e, ok;
        time         t0, t1, t2;
        int          n0;
        int unsigned idx;
        logic [31:0] d;
        logic [3:0]  s;

        bus_idle();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        idle(1);

        // Reset values and unmapped access
        rd(0, r); check("rst_ctrl", r, 32'd0);
        rd(1, r); check("rst_prescale", r, 32'd0);
        rd(2, r); check("rst_compare", r, 32'hFFFF_FFFF);
        rd(3, r); check("rst_count", r, 32'd0);
        rd(4, r); check("rst_status", r, 32'd0);
        check("rst_int", 32'(int_o), 32'd0);
        xfer(1'b0, 6, 32'd0, 4'hF, r, e);
        check("unmapped_err", 32'(e), 32'd1);
        check("unmapped_dat", r, 32'd0);

        // Byte write
        xfer(1'b1, 2, 32'hAABB_CCDD, 4'b0010, r, e);
        rd(2, r); check("byte_wr_compare", r, 32'hFFFF_CCFF);

        // Held strobe: two acks in four edges
        n0 = acks_seen;
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 0; bus.wb_adr_i = 5'h00; bus.wb_sel_i = 4'hF;
        idle(4);
        bus_idle();
        idle(1);
        check("held_stb_acks", 32'(acks_seen - n0), 32'd2);

        // Periodic: (C+1)(P+1) = 20 clocks between ack and match
        wr(1, 3); wr(2, 4); wr(0, 7);
        t0 = t_edge;
        wait_int(t1, ok);
        check("irq1_seen", 32'(ok), 32'd1);
        check("irq1_delay", 32'((t1 - t0) / CLK_T), 32'd20);
        wr(4, 1);
        check("irq_clear", 32'(int_o), 32'd0);
        wait_int(t2, ok);
        check("irq2_seen", 32'(ok), 32'd1);
        check("irq2_period", 32'((t2 - t1) / CLK_T), 32'd20);
        wr(0, 0); wr(4, 1);

        // One-shot
        wr(3, 0); wr(1, 0); wr(2, 2); wr(0, 5);
        idle(8);
        rd(0, r); check("oneshot_ctrl", r, 32'd4);
        rd(3, r); check("oneshot_count", r, 32'd0);
        rd(4, r); check("oneshot_match", r, 32'd1);
        check("oneshot_int", 32'(int_o), 32'd1);
        wr(0, 0);
        check("irq_masked", 32'(int_o), 32'd0);
        rd(4, r); check("masked_match_kept", r, 32'd1);
        wr(4, 1);

        // Wrap without a spurious match
        wr(2, 32'h10); wr(3, 32'hFFFF_FFFE); wr(0, 1);
        rd(3, r); check("wrap_ffffffff", r, 32'hFFFF_FFFF);
        rd(3, r); check("wrap_after", r, 32'd1);
        rd(4, r); check("wrap_no_match", r, 32'd0);
        idle(20);
        rd(4, r); check("wrap_match", r, 32'd1);
        wr(0, 0); wr(4, 1);

        // COUNT write landing on a tick
        wr(1, 0); wr(2, 32'h1000); wr(0, 1); wr(3, 32'h100); wr(0, 0);
        rd(3, r); check("count_wr_wins", r, 32'h102);

        // STATUS clear landing on a match (one-shot so no later re-set)
        wr(3, 0); wr(4, 1); wr(2, 1); wr(0, 1); wr(4, 1);
        rd(4, r); check("set_beats_clear", r, 32'd1);
        rd(0, r); check("oneshot_en_clr", r, 32'd0);

        // Reset during a transfer
        wr(1, 5); wr(2, 9);
        n0 = acks_seen;
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 1; bus.wb_adr_i = 5'h00;
        bus.wb_dat_i = 32'h7; bus.wb_sel_i = 4'hF;
        #3 rst_n = 0;
        @(posedge clk); #1;
        bus_idle();
        #2 rst_n = 1;
        @(posedge clk); #1;
        idle(3);
        check("rst_no_ack", 32'(acks_seen - n0), 32'd0);
        rd(0, r); check("rst2_ctrl", r, 32'd0);
        rd(1, r); check("rst2_prescale", r, 32'd0);
        rd(2, r); check("rst2_compare", r, 32'hFFFF_FFFF);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            idx = $urandom_range(0, 7);
            s   = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            case (idx)
                1:       d = $urandom_range(0, 5);
                2:       d = $urandom_range(0, 30);
                3:       d = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                          : 32'($urandom_range(0, 30));
                default: d = $urandom;
            endcase
            xfer(1'($urandom_range(0, 1)), idx, d, s, r, e);
            idle($urandom_range(0, 3));
        end

        idle(5);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
